lw_sha_regif_fifo: RTL and testbench

Parametrised bus-register front end for the lightweight SHA core. It decodes bus reads and writes into ID/CFG/CTL/STS/IE/HASH/DIN registers and packs bus-width DIN writes into core-width words. Packed words pass through a configurable-depth input FIFO with a valid/ready handshake to the core. It also provides sticky W1C status, a registered interrupt, DMA requests and a soft reset. It sits between the bus adapter and the SHA core.

---
 rtl/lw_sha_regif_pkg.sv | 27 ++
 rtl/lw_sha_sync_fifo.sv | 41 ++++
 rtl/lw_sha_regif_fifo.sv | 138 +++++++++++++
 tb/tb_lw_sha_regif_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lw_sha_regif_pkg.sv
// lw_sha_regif_pkg: address map, register bit positions and register types for the SHA bus front end
package lw_sha_regif_pkg;
   localparam logic [11:0] ADDR_ID   = 12'h000;
   localparam logic [11:0] ADDR_CFG  = 12'h010;
   localparam logic [11:0] ADDR_CTL  = 12'h020;
   localparam logic [11:0] ADDR_STS  = 12'h030;
   localparam logic [11:0] ADDR_IE   = 12'h040;
   localparam logic [11:0] ADDR_HASH = 12'h100;
   localparam logic [11:0] ADDR_DIN  = 12'h140;
   localparam int CFG_SRST  = 31;
   localparam int CTL_INIT  = 0;
   localparam int CTL_LAST  = 1;
   localparam int CTL_ABORT = 2;
   localparam int STS_AVL   = 0;
   localparam int STS_RDY   = 1;
   localparam int STS_DERR  = 2;
   localparam int STS_BUSY  = 3;
   localparam int STS_CNT   = 8;
   localparam logic [3:0] IE_RST = 4'h2;
   typedef struct packed {
      logic [3:0] opcode;
   } cfg_t;
   typedef struct packed {
      logic derr;
      logic avl;
   } sts_t;
endpackage

// File: rtl/lw_sha_sync_fifo.sv
// lw_sha_sync_fifo: show-ahead synchronous FIFO with flush
// ports: push_i/data_i write side, pop_i/data_o read side (head always visible),
//        flush_i empties the FIFO, full_o/empty_o/count_o report occupancy
module lw_sha_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;
   logic [WIDTH-1:0] mem [DEPTH];
   ptr_t wr_ptr, rd_ptr;
   logic do_pop, do_push;
   // the extra pointer bit separates full from empty when the index bits match
   assign count_o = wr_ptr - rd_ptr;
   assign empty_o = wr_ptr == rd_ptr;
   assign full_o  = count_o == ptr_t'(DEPTH);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= flush_i ? '0 : wr_ptr + ptr_t'(do_push);
         rd_ptr <= flush_i ? '0 : rd_ptr + ptr_t'(do_pop);
      end
   always_ff @(posedge clk_i)
      if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
endmodule

// File: rtl/lw_sha_regif_fifo.sv
// lw_sha_regif_fifo: bus register front end and input FIFO for the lightweight SHA core
// ports: wr_*/rd_* bus access with ack/valid/error pulses, data_o/valid_o/ready_i word stream
//        to the core, start/abort/last/opcode/core_srst control, done/busy/hash status from
//        the core, irq_o and DMA requests
module lw_sha_regif_fifo
   import lw_sha_regif_pkg::*;
#(
   parameter int          BUS_W      = 32,
   parameter int          WORD_W     = 64,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] ID_VAL     = 32'h0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_i,
   input  logic [11:0]           waddr_i,
   input  logic [BUS_W-1:0]      wdata_i,
   output logic                  wr_ack_o,
   input  logic                  rd_i,
   input  logic [11:0]           raddr_i,
   output logic [BUS_W-1:0]      rdata_o,
   output logic                  rd_valid_o,
   output logic                  slv_error_o,
   output logic                  irq_o,
   output logic [WORD_W-1:0]     data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  start_o,
   output logic                  abort_o,
   output logic                  last_o,
   output logic [3:0]            opcode_o,
   input  logic                  done_i,
   input  logic                  busy_i,
   input  logic [8*WORD_W-1:0]   hash_i,
   output logic                  dma_wr_req_o,
   output logic                  dma_rd_req_o,
   output logic                  core_srst_o
);
   localparam int BB = $clog2(BUS_W/8);
   localparam logic [11:0] HASH_END = ADDR_HASH + 12'(WORD_W);
   cfg_t cfg_q;
   sts_t sts_q;
   logic [3:0] ie_q;
   logic last_q, done_q, phase_q, done_rise;
   logic [BUS_W-1:0] hi_q, rd_mux;
   logic [WORD_W-1:0] din_word;
   logic [$clog2(FIFO_DEPTH):0] count;
   logic [31:0] sts_rd;
   logic full, empty, pop, push, push_req, drop, pack, srst, abort;
   logic wr_cfg, wr_ctl, wr_sts, wr_ie, wr_din, wr_bad, hash_hit, rd_known;
   assign wr_cfg   = wr_i && waddr_i == ADDR_CFG;
   assign wr_ctl   = wr_i && waddr_i == ADDR_CTL;
   assign wr_sts   = wr_i && waddr_i == ADDR_STS;
   assign wr_ie    = wr_i && waddr_i == ADDR_IE;
   assign wr_din   = wr_i && waddr_i == ADDR_DIN;
   assign wr_bad   = wr_i && !(wr_cfg | wr_ctl | wr_sts | wr_ie | wr_din);
   assign srst     = wr_cfg && wdata_i[CFG_SRST];
   assign abort    = wr_ctl && wdata_i[CTL_ABORT];
   assign done_rise = done_i && !done_q;
   // two bus writes per word only when the core word is wider than the bus
   assign pack     = BUS_W < WORD_W && (cfg_q.opcode[2] | cfg_q.opcode[1]);
   // the high half only fills the holding register; the low half (or a full word) pushes
   assign push_req = wr_din && !(pack && !phase_q);
   assign pop      = valid_o && ready_i;
   assign drop     = push_req && full && !pop;
   assign push     = push_req && !drop;
   assign din_word = pack ? WORD_W'({hi_q, wdata_i}) : WORD_W'(wdata_i);
   assign valid_o  = !empty;
   assign dma_wr_req_o = !full;
   assign dma_rd_req_o = sts_q.avl;
   assign last_o   = last_q;
   assign opcode_o = cfg_q.opcode;
   always_comb begin
      sts_rd = '0;
      sts_rd[STS_AVL]      = sts_q.avl;
      sts_rd[STS_RDY]      = !full;
      sts_rd[STS_DERR]     = sts_q.derr;
      sts_rd[STS_BUSY]     = busy_i;
      sts_rd[STS_CNT +: 5] = 5'(count);
   end
   assign hash_hit = raddr_i >= ADDR_HASH && raddr_i < HASH_END;
   assign rd_known = hash_hit || raddr_i == ADDR_ID || raddr_i == ADDR_CFG ||
                     raddr_i == ADDR_CTL || raddr_i == ADDR_STS || raddr_i == ADDR_IE;
   assign rd_mux = raddr_i == ADDR_ID  ? BUS_W'(ID_VAL) :
                   raddr_i == ADDR_CFG ? BUS_W'(cfg_q.opcode) :
                   raddr_i == ADDR_CTL ? BUS_W'(4'(last_q) << CTL_LAST) :
                   raddr_i == ADDR_STS ? BUS_W'(sts_rd) :
                   raddr_i == ADDR_IE  ? BUS_W'(ie_q) :
                   hash_hit            ? BUS_W'(hash_i >> (raddr_i[5:BB] * BUS_W)) : '0;
   lw_sha_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (abort | srst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (din_word),
      .data_o  (data_o),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         wr_ack_o    <= 1'b0;
         rd_valid_o  <= 1'b0;
         rdata_o     <= '0;
         slv_error_o <= 1'b0;
         irq_o       <= 1'b0;
         start_o     <= 1'b0;
         abort_o     <= 1'b0;
         core_srst_o <= 1'b0;
         cfg_q       <= '0;
         sts_q       <= '0;
         ie_q        <= IE_RST;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
         phase_q     <= 1'b0;
         hi_q        <= '0;
      end else begin
         wr_ack_o     <= wr_i;
         rd_valid_o   <= rd_i;
         rdata_o      <= rd_i ? rd_mux : '0;
         slv_error_o  <= wr_bad | drop | (rd_i && !rd_known);
         irq_o        <= |(sts_rd[3:0] & ie_q);
         start_o      <= wr_ctl && wdata_i[CTL_INIT];
         abort_o      <= abort;
         core_srst_o  <= srst;
         done_q       <= done_i;
         cfg_q.opcode <= srst ? 4'h0 : wr_cfg ? wdata_i[3:0] : cfg_q.opcode;
         ie_q         <= srst ? IE_RST : wr_ie ? wdata_i[3:0] : ie_q;
         last_q       <= (srst | abort | done_rise) ? 1'b0 : last_q | (wr_ctl && wdata_i[CTL_LAST]);
         // sticky bits: a set in the same cycle wins over the W1C clear
         sts_q.avl    <= !srst && (done_rise || (sts_q.avl && !(wr_sts && wdata_i[STS_AVL])));
         sts_q.derr   <= !srst && (drop || (sts_q.derr && !(wr_sts && wdata_i[STS_DERR])));
         phase_q      <= (wr_cfg | abort) ? 1'b0 : phase_q ^ (wr_din && pack && !drop);
         hi_q         <= (wr_din && pack && !phase_q) ? wdata_i : hi_q;
      end
endmodule

// File: tb/tb_lw_sha_regif_fifo.sv
// tb_lw_sha_regif_fifo: register table, corner sequences and random FIFO traffic against a queue model
module tb_lw_sha_regif_fifo;
   import lw_sha_regif_pkg::*;
   localparam int DEPTH = 4;
   localparam logic [31:0] ID = 32'h5A17_0001;
   logic clk_i = 1'b0, rst_i = 1'b1;
   logic wr_i = 0, rd_i = 0, ready_i = 0, done_i = 0, busy_i = 0;
   logic [11:0] waddr_i = '0, raddr_i = '0;
   logic [31:0] wdata_i = '0, rdata_o;
   logic wr_ack_o, rd_valid_o, slv_error_o, irq_o, valid_o, start_o, abort_o, last_o;
   logic dma_wr_req_o, dma_rd_req_o, core_srst_o;
   logic [3:0] opcode_o;
   logic [63:0] data_o;
   logic [511:0] hash_v;
   int tests = 0, fails = 0;
   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      logic        err;
   } vec_t;
   vec_t tbl[$];
   logic [63:0] mq[$];
   logic [63:0] m_word;
   logic [31:0] rd, d, exp_rd;
   logic er, m_derr, m_ph, pre_derr, do_rd, pop, acc, drop, wide;
   logic [3:0] m_op;
   logic [31:0] m_hi;
   int op;

   lw_sha_regif_fifo #(.BUS_W(32), .WORD_W(64), .FIFO_DEPTH(DEPTH), .ID_VAL(ID)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .wr_i(wr_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .wr_ack_o(wr_ack_o), .rd_i(rd_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
      .rd_valid_o(rd_valid_o), .slv_error_o(slv_error_o), .irq_o(irq_o), .data_o(data_o),
      .valid_o(valid_o), .ready_i(ready_i), .start_o(start_o), .abort_o(abort_o),
      .last_o(last_o), .opcode_o(opcode_o), .done_i(done_i), .busy_i(busy_i),
      .hash_i(hash_v), .dma_wr_req_o(dma_wr_req_o), .dma_rd_req_o(dma_rd_req_o),
      .core_srst_o(core_srst_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [11:0] a, input logic [31:0] v);
      wr_i = 1'b1; waddr_i = a; wdata_i = v;
      cyc();
      wr_i = 1'b0;
   endtask

   task automatic bus_rd(input logic [11:0] a, output logic [31:0] v, output logic e);
      rd_i = 1'b1; raddr_i = a;
      cyc();
      rd_i = 1'b0;
      v = rdata_o;
      e = slv_error_o;
      chk($sformatf("rd_valid@%h", a), rd_valid_o, 1);
   endtask

   task automatic add(input logic w, input logic [11:0] a, input logic [31:0] v,
                      input logic [31:0] e, input logic err);
      vec_t t;
      t.wr = w; t.addr = a; t.data = v; t.exp = e; t.err = err;
      tbl.push_back(t);
   endtask

   initial begin
      for (int k = 0; k < 16; k++) hash_v[k*32 +: 32] = 32'hC0DE_0000 + k;
      repeat (3) cyc();
      chk("rst_outs", {valid_o, irq_o, start_o, abort_o, last_o, core_srst_o, slv_error_o,
                       wr_ack_o, rd_valid_o, dma_rd_req_o, opcode_o, dma_wr_req_o}, 15'h1);
      chk("rst_rdata", rdata_o, 0);
      rst_i = 1'b0;
      cyc();
      chk("post_rst", {valid_o, start_o, abort_o, core_srst_o, slv_error_o, wr_ack_o,
                       dma_wr_req_o}, 7'h1);

      add(0, ADDR_ID,   0, ID, 0);
      add(0, ADDR_STS,  0, 32'h2, 0);
      add(0, ADDR_IE,   0, 32'h2, 0);
      add(0, ADDR_CFG,  0, 0, 0);
      add(0, ADDR_CTL,  0, 0, 0);
      add(0, ADDR_DIN,  0, 0, 1);
      add(0, 12'h050,   0, 0, 1);
      add(1, ADDR_ID,   32'hFFFF, 0, 1);
      add(1, 12'h104,   32'h1, 0, 1);
      add(1, 12'h0F0,   32'h1, 0, 1);
      add(1, ADDR_IE,   32'h5, 0, 0);
      add(0, ADDR_IE,   0, 32'h5, 0);
      add(1, ADDR_CFG,  32'h8000_0003, 0, 0);
      add(0, ADDR_CFG,  0, 0, 0);
      add(0, ADDR_IE,   0, 32'h2, 0);
      add(1, ADDR_CFG,  32'h2, 0, 0);
      add(0, ADDR_CFG,  0, 32'h2, 0);
      add(1, ADDR_CTL,  32'h2, 0, 0);
      add(0, ADDR_CTL,  0, 32'h2, 0);
      add(0, 12'h100,   0, 32'hC0DE_0000, 0);
      add(0, 12'h104,   0, 32'hC0DE_0001, 0);
      add(0, 12'h13C,   0, 32'hC0DE_000F, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].wr) begin
            bus_wr(tbl[i].addr, tbl[i].data);
            chk($sformatf("vec%0d_ack", i), wr_ack_o, 1);
            chk($sformatf("vec%0d_err", i), slv_error_o, tbl[i].err);
         end else begin
            bus_rd(tbl[i].addr, rd, er);
            chk($sformatf("vec%0d_data", i), rd, tbl[i].exp);
            chk($sformatf("vec%0d_err", i), er, tbl[i].err);
         end
      end

      // wide packing: two bus writes make one core word
      chk("opcode", opcode_o, 2);
      bus_wr(ADDR_DIN, 32'hAAAA_BBBB);
      chk("pack_half_valid", valid_o, 0);
      bus_wr(ADDR_DIN, 32'hCCCC_DDDD);
      chk("pack_valid", valid_o, 1);
      chk("pack_data", data_o, 64'hAAAABBBB_CCCCDDDD);
      bus_rd(ADDR_STS, rd, er);
      chk("pack_sts", rd, 32'h102);
      ready_i = 1'b1; cyc(); ready_i = 1'b0;
      chk("pack_popped", valid_o, 0);

      // overflow, derr, irq and W1C
      bus_wr(ADDR_CFG, 32'h0);
      bus_wr(ADDR_IE, 32'h4);
      for (int i = 0; i < DEPTH; i++) begin
         bus_wr(ADDR_DIN, i + 1);
         chk($sformatf("fill%0d_err", i), slv_error_o, 0);
      end
      chk("full_dma_wr", dma_wr_req_o, 0);
      chk("full_irq0", irq_o, 0);
      bus_wr(ADDR_DIN, 32'h55);
      chk("ovf_err", slv_error_o, 1);
      chk("ovf_ack", wr_ack_o, 1);
      cyc();
      chk("ovf_irq", irq_o, 1);
      bus_rd(ADDR_STS, rd, er);
      chk("ovf_sts", rd, 32'h404);
      bus_wr(ADDR_STS, 32'h4);
      bus_rd(ADDR_STS, rd, er);
      chk("w1c_sts", rd, 32'h400);
      ready_i = 1'b1;
      bus_wr(ADDR_DIN, 32'h66);
      ready_i = 1'b0;
      chk("full_pushpop_err", slv_error_o, 0);
      chk("full_pushpop_head", data_o, 64'h2);
      bus_rd(ADDR_STS, rd, er);
      chk("full_pushpop_sts", rd, 32'h400);

      // init + abort, flush and packing-phase reset
      chk("last_before", last_o, 1);
      bus_wr(ADDR_CTL, 32'h5);
      chk("ctl5_pulses", {start_o, abort_o}, 2'b11);
      chk("ctl5_flush", valid_o, 0);
      chk("ctl5_last", last_o, 0);
      cyc();
      chk("ctl5_pulse_end", {start_o, abort_o}, 2'b00);
      bus_rd(ADDR_STS, rd, er);
      chk("ctl5_sts", rd, 32'h2);
      bus_wr(ADDR_CFG, 32'h2);
      bus_wr(ADDR_DIN, 32'h1111_1111);
      bus_wr(ADDR_CTL, 32'h5);
      bus_wr(ADDR_DIN, 32'h2222_2222);
      chk("phase_half", valid_o, 0);
      bus_wr(ADDR_DIN, 32'h3333_3333);
      chk("phase_data", data_o, 64'h22222222_33333333);
      bus_wr(ADDR_CTL, 32'h4);
      chk("abort_flush", valid_o, 0);

      // done -> avl, irq and hash read
      bus_wr(ADDR_IE, 32'h1);
      bus_wr(ADDR_CTL, 32'h2);
      chk("last_set", last_o, 1);
      done_i = 1'b1; cyc(); done_i = 1'b0;
      chk("done_avl", dma_rd_req_o, 1);
      chk("done_last", last_o, 0);
      chk("done_irq_lag", irq_o, 0);
      cyc();
      chk("done_irq", irq_o, 1);
      bus_rd(ADDR_STS, rd, er);
      chk("done_sts", rd, 32'h3);
      bus_rd(12'h104, rd, er);
      chk("hash_104", rd, hash_v[63:32]);
      bus_wr(ADDR_STS, 32'h1);
      chk("avl_w1c", dma_rd_req_o, 0);

      // soft reset, then random traffic against a queue model
      bus_wr(ADDR_CFG, 32'h8000_0000);
      chk("srst_pulse", core_srst_o, 1);
      cyc();
      chk("srst_pulse_end", core_srst_o, 0);
      bus_wr(ADDR_IE, 32'h4);
      m_derr = 0; m_ph = 0; m_op = 0; m_hi = 0;
      mq.delete();
      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 9);
         d = $urandom;
         do_rd = $urandom_range(0, 3) == 0;
         ready_i = 1'($urandom_range(0, 1));
         exp_rd = {19'b0, 5'(mq.size()), 4'b0, 1'b0, m_derr, 1'(mq.size() < DEPTH), 1'b0};
         pre_derr = m_derr;
         pop = mq.size() > 0 && ready_i;
         wide = m_op[2] | m_op[1];
         acc = 0; drop = 0;
         rd_i = do_rd; raddr_i = ADDR_STS;
         wr_i = op < 8;
         if (op < 6) begin
            waddr_i = ADDR_DIN; wdata_i = d;
            if (wide && !m_ph) begin
               m_hi = d; m_ph = 1;
            end else begin
               m_word = wide ? {m_hi, d} : {32'h0, d};
               acc = mq.size() < DEPTH || pop;
               drop = !acc;
               if (acc) m_ph = 0;
            end
         end else if (op == 6) begin
            waddr_i = ADDR_STS; wdata_i = 32'h4;
            m_derr = 0;
         end else if (op == 7) begin
            m_op = 4'($urandom_range(0, 15));
            waddr_i = ADDR_CFG; wdata_i = {28'h0, m_op};
            m_ph = 0;
         end
         cyc();
         wr_i = 0; rd_i = 0;
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(m_word);
         if (drop) m_derr = 1;
         chk($sformatf("rnd%0d_valid", n), valid_o, mq.size() != 0);
         if (mq.size() != 0) chk($sformatf("rnd%0d_data", n), data_o, mq[0]);
         chk($sformatf("rnd%0d_dmawr", n), dma_wr_req_o, mq.size() < DEPTH);
         chk($sformatf("rnd%0d_err", n), slv_error_o, drop);
         chk($sformatf("rnd%0d_ack", n), wr_ack_o, op < 8);
         chk($sformatf("rnd%0d_irq", n), irq_o, pre_derr);
         if (do_rd) begin
            chk($sformatf("rnd%0d_rdv", n), rd_valid_o, 1);
            chk($sformatf("rnd%0d_sts", n), rdata_o, exp_rd);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
